// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-requester (I-cache / D-cache) memory bus arbiter and
//               burst sequencer. Grants one requester at a time round-robin,
//               runs an address phase followed by BEATS data beats, then
//               pulses done to the owner.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset         clock / synchronous active-high reset
//   ic_req, ic_addr    I-cache line-fill request and miss address
//   ic_gnt             one-cycle pulse: I-cache owns the bus
//   ic_rvalid/rdata    fill beats for the I-cache
//   ic_done            one-cycle pulse: I-cache transfer complete
//   dc_req, dc_addr    D-cache request and address
//   dc_we, dc_wdata    write-back select and current write-back beat
//   dc_gnt/rvalid/rdata/done  D-cache equivalents of the I-cache outputs
//   dc_wready          dc_wdata beat consumed this cycle
//   mem_req/addr/we    memory address phase (line-aligned address)
//   mem_ack            address phase accepted
//   mem_rvalid/rdata   memory read beat
//   mem_wready         memory accepts write beat
//   mem_wdata          write beat to memory
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int BEATS      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ic_req,
    input  logic [ADDR_WIDTH-1:0] ic_addr,
    output logic                  ic_gnt,
    output logic                  ic_rvalid,
    output logic [DATA_WIDTH-1:0] ic_rdata,
    output logic                  ic_done,
    input  logic                  dc_req,
    input  logic [ADDR_WIDTH-1:0] dc_addr,
    input  logic                  dc_we,
    input  logic [DATA_WIDTH-1:0] dc_wdata,
    output logic                  dc_gnt,
    output logic                  dc_rvalid,
    output logic [DATA_WIDTH-1:0] dc_rdata,
    output logic                  dc_done,
    output logic                  dc_wready,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    input  logic                  mem_ack,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_wready,
    output logic [DATA_WIDTH-1:0] mem_wdata
);

    localparam int c_CNT_W = $clog2(BEATS);
    localparam int c_OFF_W = $clog2(BEATS * DATA_WIDTH / 8);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_ADDR  = 3'd1;
    localparam logic [2:0] c_ST_RDATA = 3'd2;
    localparam logic [2:0] c_ST_WDATA = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    localparam logic c_OWN_I = 1'b0;
    localparam logic c_OWN_D = 1'b1;

    localparam logic [c_CNT_W-1:0]    c_LAST_BEAT = c_CNT_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] c_LINE_MASK = {ADDR_WIDTH{1'b1}} << c_OFF_W;

    logic [2:0]            r_state;
    logic                  r_owner;
    logic                  r_last_owner;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_we;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_first;      // high only in the first ADDR cycle

    logic [2:0]            w_state_nxt;
    logic                  w_any_req;
    logic                  w_pick_d;
    logic                  w_beat;
    logic                  w_last_beat;

    // Arbitration: a lone requester wins; on a tie the one that did not
    // own the bus last time wins.
    always_comb begin
        w_any_req   = ic_req | dc_req;
        w_pick_d    = dc_req & (~ic_req | (r_last_owner == c_OWN_I));
        w_beat      = ((r_state == c_ST_RDATA) & mem_rvalid) |
                      ((r_state == c_ST_WDATA) & mem_wready);
        w_last_beat = w_beat & (r_cnt == c_LAST_BEAT);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_any_req) w_state_nxt = c_ST_ADDR;
            c_ST_ADDR:  if (mem_ack)   w_state_nxt = r_we ? c_ST_WDATA : c_ST_RDATA;
            c_ST_RDATA: if (w_last_beat) w_state_nxt = c_ST_DONE;
            c_ST_WDATA: if (w_last_beat) w_state_nxt = c_ST_DONE;
            c_ST_DONE:  w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_owner      <= c_OWN_I;
            r_last_owner <= c_OWN_D;     // first tie goes to the I-cache
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_cnt        <= '0;
            r_first      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_first <= (r_state == c_ST_IDLE) & w_any_req;

            if ((r_state == c_ST_IDLE) && w_any_req) begin
                r_owner <= w_pick_d;
                r_addr  <= (w_pick_d ? dc_addr : ic_addr) & c_LINE_MASK;
                r_we    <= w_pick_d & dc_we;   // I-cache only ever reads
            end

            if ((r_state == c_ST_ADDR) && mem_ack) begin
                r_cnt <= '0;
            end else if (w_beat) begin
                r_cnt <= w_last_beat ? '0 : r_cnt + c_CNT_W'(1);
            end

            if (r_state == c_ST_DONE) begin
                r_last_owner <= r_owner;
            end
        end
    end

    always_comb begin
        ic_gnt    = 1'b0;
        ic_rvalid = 1'b0;
        ic_rdata  = '0;
        ic_done   = 1'b0;
        dc_gnt    = 1'b0;
        dc_rvalid = 1'b0;
        dc_rdata  = '0;
        dc_done   = 1'b0;
        dc_wready = 1'b0;
        mem_req   = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (r_state)
            c_ST_ADDR: begin
                mem_req  = 1'b1;
                mem_addr = r_addr;
                mem_we   = r_we;
                ic_gnt   = r_first & (r_owner == c_OWN_I);
                dc_gnt   = r_first & (r_owner == c_OWN_D);
            end
            c_ST_RDATA: begin
                if (r_owner == c_OWN_I) begin
                    ic_rvalid = mem_rvalid;
                    ic_rdata  = mem_rdata;
                end else begin
                    dc_rvalid = mem_rvalid;
                    dc_rdata  = mem_rdata;
                end
            end
            c_ST_WDATA: begin
                // Only the D-cache can own a write burst.
                mem_wdata = dc_wdata;
                dc_wready = mem_wready;
            end
            c_ST_DONE: begin
                ic_done = (r_owner == c_OWN_I);
                dc_done = (r_owner == c_OWN_D);
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. A transaction-level
//               model predicts every output each cycle; directed scenarios
//               add literal expectations for addresses, grant order, beat
//               counts and latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int AW         = 64;
    localparam int DW         = 64;
    localparam int NB         = 8;
    localparam int LINE_BYTES = NB * DW / 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ic_req = 1'b0;
    logic [AW-1:0] ic_addr = '0;
    logic          ic_gnt, ic_rvalid, ic_done;
    logic [DW-1:0] ic_rdata;
    logic          dc_req = 1'b0;
    logic [AW-1:0] dc_addr = '0;
    logic          dc_we = 1'b0;
    logic [DW-1:0] dc_wdata = '0;
    logic          dc_gnt, dc_rvalid, dc_done, dc_wready;
    logic [DW-1:0] dc_rdata;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic          mem_ack = 1'b0;
    logic          mem_rvalid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_wready = 1'b0;
    logic [DW-1:0] mem_wdata;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEATS(NB)) u_dut (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt),
        .ic_rvalid(ic_rvalid), .ic_rdata(ic_rdata), .ic_done(ic_done),
        .dc_req(dc_req), .dc_addr(dc_addr), .dc_we(dc_we), .dc_wdata(dc_wdata),
        .dc_gnt(dc_gnt), .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata),
        .dc_done(dc_done), .dc_wready(dc_wready),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .mem_wready(mem_wready), .mem_wdata(mem_wdata)
    );

    initial forever #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endfunction

    // Transaction-level model: one burst in flight or none.
    bit          m_valid = 1'b0;
    bit          m_busy  = 1'b0;   // granted, done not yet reached
    bit          m_acked = 1'b0;   // address phase accepted
    bit          m_we    = 1'b0;
    bit          m_own   = 1'b0;   // 0 = I-cache, 1 = D-cache
    bit          m_gnt   = 1'b0;
    bit          m_done  = 1'b0;
    bit          m_last  = 1'b1;
    int          m_left  = 0;
    logic [63:0] m_addr  = '0;
    logic [63:0] m_raw   = '0;

    int grant_log[$];
    int n_ic_rv = 0, n_dc_wr = 0, n_ic_done = 0, n_dc_done = 0;

    always @(negedge clk) begin
        if (m_valid) begin
            chk("ic_gnt",    64'(ic_gnt),    64'(m_gnt && !m_own));
            chk("dc_gnt",    64'(dc_gnt),    64'(m_gnt &&  m_own));
            chk("mem_req",   64'(mem_req),   64'(m_busy && !m_acked));
            chk("mem_addr",  mem_addr,       (m_busy && !m_acked) ? m_addr : 64'd0);
            chk("mem_we",    64'(mem_we),    64'(m_busy && !m_acked && m_we));
            chk("ic_rvalid", 64'(ic_rvalid), 64'(m_busy && m_acked && !m_we && !m_own && mem_rvalid));
            chk("ic_rdata",  ic_rdata,       (m_busy && m_acked && !m_we && !m_own) ? mem_rdata : 64'd0);
            chk("dc_rvalid", 64'(dc_rvalid), 64'(m_busy && m_acked && !m_we && m_own && mem_rvalid));
            chk("dc_rdata",  dc_rdata,       (m_busy && m_acked && !m_we && m_own) ? mem_rdata : 64'd0);
            chk("mem_wdata", mem_wdata,      (m_busy && m_acked && m_we) ? dc_wdata : 64'd0);
            chk("dc_wready", 64'(dc_wready), 64'(m_busy && m_acked && m_we && mem_wready));
            chk("ic_done",   64'(ic_done),   64'(m_done && !m_own));
            chk("dc_done",   64'(dc_done),   64'(m_done &&  m_own));
        end
        if (ic_gnt)    grant_log.push_back(0);
        if (dc_gnt)    grant_log.push_back(1);
        if (ic_rvalid) n_ic_rv++;
        if (dc_wready) n_dc_wr++;
        if (ic_done)   n_ic_done++;
        if (dc_done)   n_dc_done++;

        // Advance the model with this cycle's inputs.
        if (reset) begin
            m_valid = 1'b1; m_busy = 1'b0; m_acked = 1'b0; m_gnt = 1'b0;
            m_done = 1'b0; m_last = 1'b1; m_own = 1'b0;
        end else if (m_valid) begin
            if (m_done) begin
                m_done = 1'b0;
                m_last = m_own;
            end else if (!m_busy) begin
                if (ic_req || dc_req) begin
                    m_own   = (ic_req && dc_req) ? !m_last : dc_req;
                    m_busy  = 1'b1;
                    m_acked = 1'b0;
                    m_gnt   = 1'b1;
                    m_raw   = m_own ? dc_addr : ic_addr;
                    m_addr  = m_raw - (m_raw % LINE_BYTES);
                    m_we    = m_own && dc_we;
                end
            end else begin
                m_gnt = 1'b0;
                if (!m_acked) begin
                    if (mem_ack) begin
                        m_acked = 1'b1;
                        m_left  = NB;
                    end
                end else if (m_we ? mem_wready : mem_rvalid) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the first ADDR cycle; returns in the DONE cycle.
    // Spurious beats are driven during the wait and in the ack cycle.
    task automatic read_burst(input int ack_delay, input logic [63:0] base);
        for (int d = 0; d < ack_delay; d++) begin
            mem_ack = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hBAD0 + 64'(d);
            tick();
        end
        mem_ack = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'hBADF;
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < NB; i++) begin
            mem_rvalid = 1'b1; mem_rdata = base + 64'(i);
            tick();
        end
        mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    int t_req, rv0, wr0, g0, d0;

    initial begin
        tick();
        #1;
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_ic_gnt",  64'(ic_gnt),  64'd0);
        chk("rst_mem_addr", mem_addr,    64'd0);
        reset = 1'b0;

        // S1: single I-cache fill
        ic_req = 1'b1; ic_addr = 64'h1234; t_req = cyc;
        tick(); #1;
        chk("s1_gnt",  64'(ic_gnt),  64'd1);
        chk("s1_addr", mem_addr,     64'h1200);
        chk("s1_we",   64'(mem_we),  64'd0);
        rv0 = n_ic_rv;
        read_burst(0, 64'h0);
        #1;
        chk("s1_done", 64'(ic_done), 64'd1);
        chk("s1_rvcount", 64'(n_ic_rv - rv0), 64'd8);
        chk("s1_latency", 64'(cyc - t_req), 64'd10);  // 11 cycles counted inclusively
        ic_req = 1'b0;
        tick();

        // S2: D-cache write-back with throttled wready
        dc_req = 1'b1; dc_we = 1'b1; dc_addr = 64'h8040;
        tick(); #1;
        chk("s2_gnt",  64'(dc_gnt), 64'd1);
        chk("s2_we",   64'(mem_we), 64'd1);
        chk("s2_addr", mem_addr,    64'h8040);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        wr0 = n_dc_wr;
        for (int i = 0; i < 15; i++) begin
            mem_wready = (i % 2 == 0);
            dc_wdata   = 64'hD00D_0000 + 64'(i);
            tick();
        end
        mem_wready = 1'b0;
        #1;
        chk("s2_done", 64'(dc_done), 64'd1);
        chk("s2_wrcount", 64'(n_dc_wr - wr0), 64'd8);
        dc_req = 1'b0; dc_we = 1'b0;
        tick();

        // S3: continuous contention from reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        g0 = grant_log.size();
        ic_req = 1'b1; ic_addr = 64'h2000; dc_req = 1'b1; dc_addr = 64'h40C0;
        tick();
        read_burst(0, 64'h100);
        tick(); tick(); #1;
        chk("s3_dgnt", 64'(dc_gnt), 64'd1);
        read_burst(0, 64'h200);
        tick(); tick(); #1;
        chk("s3_ignt", 64'(ic_gnt), 64'd1);
        read_burst(0, 64'h300);
        ic_req = 1'b0; dc_req = 1'b0;
        tick();
        chk("s3_ngrants", 64'(grant_log.size() - g0), 64'd3);
        if (grant_log.size() - g0 >= 3) begin
            chk("s3_order0", 64'(grant_log[g0]),     64'd0);
            chk("s3_order1", 64'(grant_log[g0 + 1]), 64'd1);
            chk("s3_order2", 64'(grant_log[g0 + 2]), 64'd0);
        end

        // S4: delayed ack with spurious beats before it
        ic_req = 1'b1; ic_addr = 64'h5678;
        tick();
        rv0 = n_ic_rv;
        read_burst(5, 64'h400);
        #1;
        chk("s4_done", 64'(ic_done), 64'd1);
        chk("s4_rvcount", 64'(n_ic_rv - rv0), 64'd8);
        ic_req = 1'b0;
        tick();

        // S5: reset after beat 3, then restart
        ic_req = 1'b1; ic_addr = 64'h9000;
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_rvalid = 1'b1; mem_rdata = 64'hA0 + 64'(i);
            tick();
        end
        mem_rvalid = 1'b0;
        d0 = n_ic_done;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("s5_rst_req",  64'(mem_req),  64'd0);
        chk("s5_rst_done", 64'(ic_done),  64'd0);
        chk("s5_rst_addr", mem_addr,      64'd0);
        tick(); #1;
        chk("s5_regnt", 64'(ic_gnt), 64'd1);
        rv0 = n_ic_rv;
        read_burst(0, 64'h500);
        #1;
        chk("s5_done", 64'(ic_done), 64'd1);
        chk("s5_rvcount", 64'(n_ic_rv - rv0), 64'd8);
        ic_req = 1'b0;
        tick();
        chk("s5_donecount", 64'(n_ic_done - d0), 64'd1);

        // S6: request dropped right after grant
        ic_req = 1'b1; ic_addr = 64'h00A0;
        tick();
        ic_req = 1'b0;
        read_burst(2, 64'h600);
        #1;
        chk("s6_done", 64'(ic_done), 64'd1);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        miscompares++;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester memory bus arbiter and transfer sequencer. The I-cache and D-cache miss/write-back paths share the single memory port through this block. It grants one requester at a time round-robin, issues one line-sized burst (address phase, then BEATS data beats) and signals completion to the owner. It sits between both caches and the memory/bus interface.

## Interface
- ADDR_WIDTH, 64, address width
- DATA_WIDTH, 64, beat width
- BEATS, 8, beats per line; power of two, ≥2 (line = 64 B at defaults)
- clk  in  1  clock; all state changes on posedge
- reset  in  1  synchronous, active-high
- ic_req  in  1  I-cache line-fill request; held until ic_done
- ic_addr  in  ADDR_WIDTH  I-cache miss address
- ic_gnt  out  1  one-cycle pulse: I-cache owns the bus
- ic_rvalid  out  1  fill beat valid for I-cache
- ic_rdata  out  DATA_WIDTH  fill beat data
- ic_done  out  1  one-cycle pulse: I-cache transfer complete
- dc_req  in  1  D-cache request; held until dc_done
- dc_addr  in  ADDR_WIDTH  D-cache address
- dc_we  in  1  1 = write-back burst, 0 = line fill
- dc_wdata  in  DATA_WIDTH  current write-back beat
- dc_gnt / dc_rvalid / dc_rdata / dc_done  out  1/1/DATA_WIDTH/1  as I-cache equivalents
- dc_wready  out  1  dc_wdata beat consumed this cycle
- mem_req  out  1  address-phase request
- mem_addr  out  ADDR_WIDTH  line-aligned burst address
- mem_we  out  1  burst direction
- mem_ack  in  1  address phase accepted
- mem_rvalid  in  1  read beat valid
- mem_rdata  in  DATA_WIDTH  read beat
- mem_wready  in  1  memory accepts write beat
- mem_wdata  out  DATA_WIDTH  write beat

## Operation
- States: IDLE, ADDR, RDATA, WDATA, DONE. Registers: state, owner (I/D), last_owner, latched addr, latched we, beat counter (log2(BEATS) bits).
- IDLE: with no request, stay. With one request, grant it. With both, grant the one ≠ last_owner. On grant, latch owner, address with low log2(BEATS·DATA_WIDTH/8) bits cleared, and we (forced 0 for I-cache). Go to ADDR. Owner's gnt is high for exactly the first ADDR cycle.
- ADDR: mem_req=1; mem_addr and mem_we come from latches. When mem_ack=1, go to RDATA (we=0) or WDATA (we=1) and clear the counter.
- RDATA: owner_rvalid=mem_rvalid and owner_rdata=mem_rdata, combinational. Non-owner rvalid=0 and rdata=0. Each mem_rvalid increments the counter. The BEATS-th beat goes to DONE.
- WDATA: mem_wdata=dc_wdata and dc_wready=mem_wready, combinational. Each mem_wready increments the counter. The BEATS-th beat goes to DONE.
- DONE: owner_done=1 for one cycle. last_owner←owner. Go to IDLE.
- Outputs outside their state: mem_req=0, mem_addr=0, mem_we=0, mem_wdata=0, all rvalid/wready/done/gnt=0.
- Requests are not re-sampled after grant. A req deasserted mid-burst does not abort the burst; it completes.
- Beats arriving outside RDATA/WDATA are ignored. mem_rvalid in the same cycle as mem_ack is ignored; the first beat counts from the cycle after ack.
- The counter wraps to 0 when the BEATS-th beat is counted.

## Timing
- Reset: state=IDLE, counter=0, owner=I, last_owner=D (the first tie goes to I-cache). Every output is 0 in the cycle after reset is sampled.
- Reset mid-burst aborts the transfer. No done is issued. mem_req is 0 in the next cycle.
- req high in cycle N (IDLE) → gnt and mem_req high in N+1.
- mem_ack at cycle A → first beat is countable at A+1.
- Last beat at cycle L → done at L+1 → IDLE at L+2. The earliest next grant is then visible at L+3.
- Minimum read burst with mem_ack on the first ADDR cycle and back-to-back beats: req→done = 3+BEATS cycles.
- With continuous contention, grants strictly alternate.

## Test plan
- Reset, then ic_req=1 with ic_addr=0x1234: ic_gnt pulses once; mem_req=1 with mem_addr=0x1200 and mem_we=0. Ack, then 8 beats 0x0..0x7 → ic_rvalid ×8 carrying the same data, then ic_done 1 cycle after beat 8, with dc_* silent throughout.
- dc_req with dc_we=1 and dc_addr=0x8040, with mem_wready toggling 1,0,1,…: exactly 8 dc_wready pulses; mem_wdata tracks dc_wdata; dc_done follows the 8th accepted beat; mem_we=1.
- ic_req and dc_req both high from reset and held: I granted first, then D, then I. No done is ever issued to the non-owner.
- mem_ack delayed 5 cycles: mem_req and mem_addr stay stable; mem_rvalid pulses injected during ADDR and in the ack cycle do not count; exactly 8 later beats complete the burst.
- Reset asserted after beat 3 of a read: all outputs 0 next cycle, no ic_done, and a new request restarts at beat count 0.
- ic_req dropped after grant: the burst still completes and ic_done pulses.
